// File: rtl/bcd_field_sel_one_hot_pipe_pkg.sv
// Shared router package: select-mode constants, skid state encoding and a clog2 helper.
package bcd_field_sel_one_hot_pipe_pkg;

  localparam int SEL_MODE_BIN     = 0;
  localparam int SEL_MODE_ONE_HOT = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // Never returns less than 1 so a select port always has a legal width.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_field_sel_one_hot_pipe_skid.sv
// Generic 2-entry valid/ready register; full throughput, in_ready driven from state only.
//   state    | meaning
//   ST_EMPTY | main and skid both empty
//   ST_ONE   | main holds the head beat, skid empty
//   ST_TWO   | main holds the head beat, skid holds the next one
module skid_reg_2entry
  import bcd_field_sel_one_hot_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  skid_state_e  state_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         push;
  logic         pop;

  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_q  <= in_data;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            skid_q  <= in_data;
            state_q <= ST_TWO;
          end else if (push && pop) begin
            main_q <= in_data;
          end else if (pop) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_q  <= skid_q;
            state_q <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/bcd_field_sel_one_hot_pipe.sv
// Field mux + one-hot decoder with range check, registered through a 2-entry skid stage.
module bcd_field_sel_one_hot_pipe
  import bcd_field_sel_one_hot_pipe_pkg::*;
#(
  parameter int FIELD_W     = 2,
  parameter int NUM_FIELDS  = 4,
  parameter int SEL_ONE_HOT = 0,
  parameter int OUT_W       = 2 ** FIELD_W,
  parameter int ERR_CNT_W   = 8,
  localparam int IN_W  = FIELD_W * NUM_FIELDS,
  localparam int SEL_W = (SEL_ONE_HOT == SEL_MODE_ONE_HOT) ? NUM_FIELDS : clog2(NUM_FIELDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_W-1:0]      mux_in,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_W-1:0]     out_one_hot,
  output logic [FIELD_W-1:0]   out_bcd,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int W = OUT_W + FIELD_W + 1;

  logic                 sel_ok;
  int                   fld_idx;
  logic [OUT_W-1:0]     dec_oh;
  logic [FIELD_W-1:0]   dec_bcd;
  logic                 dec_err;
  logic [W-1:0]         out_data;
  logic                 push;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  generate
    if (SEL_ONE_HOT == SEL_MODE_ONE_HOT) begin : g_sel_oh
      always_comb begin
        sel_ok  = $onehot(sel);
        fld_idx = 0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
          if (sel[k]) fld_idx = k;
        end
      end
    end else begin : g_sel_bin
      assign sel_ok  = (32'(sel) < NUM_FIELDS);
      assign fld_idx = int'(32'(sel));
    end
  endgenerate

  // A bad select reports bcd=0; an out-of-range value still reports its bcd.
  always_comb begin
    dec_bcd = '0;
    dec_oh  = '0;
    dec_err = 1'b1;
    if (sel_ok) begin
      dec_bcd = mux_in[fld_idx*FIELD_W +: FIELD_W];
      if (32'(dec_bcd) < OUT_W) begin
        dec_oh[dec_bcd] = 1'b1;
        dec_err         = 1'b0;
      end
    end
  end

  skid_reg_2entry #(.W(W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_data   ({dec_oh, dec_bcd, dec_err}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign {out_one_hot, out_bcd, out_err} = out_data;

  assign push      = in_valid & in_ready;
  assign err_cnt_d = (push && dec_err && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;

endmodule
